// File: rtl/usb_pe_out_sequencer.sv
// USB full-speed OUT/SETUP data+handshake sequencer: receives DATA0/DATA1, fills the
// endpoint OUT FIFO, commits or rolls back, tracks data toggles and returns ACK/NAK/STALL.
`timescale 1ns/1ps
module usb_pe_out_sequencer #(
   parameter int ENDPOINTS      = 4,
   parameter int EP_DATA_WID    = 8,
   parameter int TIMEOUT_CYCLES = 96
) (
   input  logic                         clk48,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [3:0]                   tokEp,
   input  logic                         tokIsSetup,
   input  logic [ENDPOINTS-1:0]         epStall,
   input  logic                         resetToggles,
   output logic                         busy,
   output logic [$clog2(ENDPOINTS):0]   epSelect,
   output logic                         rxAcceptNewData,
   input  logic [7:0]                   rxData,
   input  logic                         rxIsLastByte,
   input  logic                         rxDataValid,
   input  logic                         keepPacket,
   output logic                         WRITE_EN,
   output logic [EP_DATA_WID-1:0]       wdata,
   input  logic                         writeFifoFull,
   output logic                         fillTransDone,
   output logic                         fillTransSuccess,
   output logic                         txReqSendPacket,
   output logic                         txDataValid,
   output logic                         txIsLastByte,
   output logic [7:0]                   txData,
   input  logic                         txAcceptNewData
);

   localparam int EPW = $clog2(ENDPOINTS) + 1;
   localparam int EIW = (ENDPOINTS > 1) ? $clog2(ENDPOINTS) : 1;
   localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;
   localparam logic [7:0] PID_STALL = 8'h1E;

   typedef enum logic [2:0] {
      S_IDLE, S_AWAIT_PID, S_RECV, S_DISCARD, S_COMMIT, S_SEND_HS
   } state_e;

   typedef enum logic [1:0] {
      M_ACCEPT, M_DUP, M_STALL
   } mode_e;

   state_e               state_q, state_d;
   mode_e                mode_q, mode_d;
   logic [EPW-1:0]       ep_q, ep_d;
   logic                 setup_q, setup_d;
   logic                 ovf_q, ovf_d;
   logic                 keep_q, keep_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [7:0]           hs_q, hs_d;
   logic [ENDPOINTS-1:0] tog_q, tog_d;

   logic [EIW-1:0]       ep_idx;
   logic                 ep_ok;
   logic                 pid_tog;

   assign ep_idx   = ep_q[EIW-1:0];
   assign ep_ok    = ({28'd0, tokEp} < 32'(ENDPOINTS));
   assign busy     = (state_q != S_IDLE);
   assign epSelect = ep_q;

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= M_ACCEPT;
         ep_q    <= '0;
         setup_q <= 1'b0;
         ovf_q   <= 1'b0;
         keep_q  <= 1'b0;
         timer_q <= '0;
         hs_q    <= 8'h00;
         tog_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         ep_q    <= ep_d;
         setup_q <= setup_d;
         ovf_q   <= ovf_d;
         keep_q  <= keep_d;
         timer_q <= timer_d;
         hs_q    <= hs_d;
         tog_q   <= tog_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      mode_d           = mode_q;
      ep_d             = ep_q;
      setup_d          = setup_q;
      ovf_d            = ovf_q;
      keep_d           = keep_q;
      timer_d          = timer_q;
      hs_d             = hs_q;
      tog_d            = tog_q;
      pid_tog          = (rxData == PID_DATA1);
      rxAcceptNewData  = 1'b0;
      WRITE_EN         = 1'b0;
      wdata            = '0;
      fillTransDone    = 1'b0;
      fillTransSuccess = 1'b0;
      txReqSendPacket  = 1'b0;
      txDataValid      = 1'b0;
      txIsLastByte     = 1'b0;
      txData           = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (start && ep_ok) begin
               ep_d    = EPW'(tokEp);
               setup_d = tokIsSetup;
               timer_d = '0;
               ovf_d   = 1'b0;
               keep_d  = 1'b0;
               state_d = S_AWAIT_PID;
            end
         end

         S_AWAIT_PID: begin
            rxAcceptNewData = 1'b1;
            if (rxDataValid) begin
               if (rxData == PID_DATA0 || rxData == PID_DATA1) begin
                  // SETUP always restarts the endpoint at DATA0 and overrides a halt
                  if (setup_q) begin
                     tog_d[ep_idx] = 1'b0;
                     mode_d        = M_ACCEPT;
                  end else if (epStall[ep_idx]) begin
                     mode_d = M_STALL;
                  end else if (pid_tog != tog_q[ep_idx]) begin
                     mode_d = M_DUP;
                  end else begin
                     mode_d = M_ACCEPT;
                  end
                  keep_d  = keepPacket;
                  state_d = rxIsLastByte ? S_COMMIT : S_RECV;
               end else begin
                  state_d = rxIsLastByte ? S_IDLE : S_DISCARD;
               end
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_RECV: begin
            rxAcceptNewData = 1'b1;
            if (rxDataValid) begin
               if (mode_q == M_ACCEPT) begin
                  // once the FIFO has refused a byte the packet is lost; stop writing
                  if (writeFifoFull) begin
                     ovf_d = 1'b1;
                  end else if (!ovf_q) begin
                     WRITE_EN = 1'b1;
                     wdata    = EP_DATA_WID'(rxData);
                  end
               end
               if (rxIsLastByte) begin
                  keep_d  = keepPacket;
                  state_d = S_COMMIT;
               end
            end
         end

         S_DISCARD: begin
            rxAcceptNewData = 1'b1;
            if (rxDataValid && rxIsLastByte) state_d = S_IDLE;
         end

         S_COMMIT: begin
            if (mode_q == M_ACCEPT) begin
               fillTransDone    = 1'b1;
               fillTransSuccess = keep_q && !ovf_q;
            end
            if (!keep_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_SEND_HS;
               case (mode_q)
                  M_ACCEPT: begin
                     if (ovf_q) begin
                        hs_d = PID_NAK;
                     end else begin
                        hs_d          = PID_ACK;
                        tog_d[ep_idx] = ~tog_q[ep_idx];
                     end
                  end
                  M_DUP:    hs_d = PID_ACK;
                  default:  hs_d = PID_STALL;
               endcase
            end
         end

         S_SEND_HS: begin
            txReqSendPacket = 1'b1;
            txDataValid     = 1'b1;
            txIsLastByte    = 1'b1;
            txData          = hs_q;
            if (txAcceptNewData) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      if (resetToggles) tog_d = '0;
   end

endmodule
